sad_trigger_ctrl: RTL and testbench
===================================

Name: sad_trigger_ctrl

Overview:
- Sequencer and configuration front-end for the HLS-generated SAD core.
- Holds the reference waveform in a local RAM and starts the core. Streams the stored reference points into the core's ref FIFO port, then forwards ADC samples into its data FIFO port.
- Compares each SAD result against a programmable threshold and raises a one-cycle trigger. After a trigger or an abort it recycles the core back to idle.

Parameters:
- REF_DEPTH, 128, reference RAM depth; the address width is 7 bits.
- DW, 10, sample and reference width in bits.
- SUMW, 20, SAD result width in bits.

Ports:
- ap_clk  in  1  system clock.
- ap_rst  in  1  synchronous active-high reset.
- arm  in  1  level; a rising edge while IDLE begins a sequence; deasserting it in any non-IDLE state aborts.
- num_points  in  7  reference length; sampled at arm; 0 means no start.
- threshold  in  SUMW  trigger when sum < threshold.
- ref_wr_en  in  1  reference RAM write strobe.
- ref_wr_addr  in  7  reference RAM write address.
- ref_wr_data  in  DW  signed reference point, already offset-corrected.
- adc_data  in  DW  unsigned offset-binary ADC sample.
- adc_valid  in  1  adc_data valid this cycle.
- sad_rst  out  1  reset to the core.
- sad_start  out  1  drives the core's ap_start.
- sad_idle  in  1  the core's ap_idle.
- sad_ref_dout  out  DW  drives ref_points_in_V_dout.
- sad_ref_empty_n  out  1  drives ref_points_in_V_empty_n.
- sad_ref_read  in  1  the core's ref_points_in_V_read.
- sad_data_dout  out  DW  drives datain_V_dout.
- sad_data_empty_n  out  1  drives datain_V_empty_n.
- sad_data_read  in  1  the core's datain_V_read.
- sad_sum_din  in  SUMW  the core's sumout_V_din.
- sad_sum_write  in  1  the core's sumout_V_write.
- sad_sum_full_n  out  1  drives sumout_V_full_n.
- trigger  out  1  one-cycle trigger pulse.
- busy  out  1  high whenever state != IDLE.
- last_sum  out  SUMW  most recent SAD result.
- overrun  out  1  sticky sample-drop flag.

Behaviour:
- Reset: synchronous; all state returns to IDLE.
  - Outputs at reset: trigger=0, busy=0, sad_start=0, sad_ref_empty_n=0, sad_data_empty_n=0, last_sum=0, overrun=0.
  - sad_rst=1 while ap_rst=1.
  - sad_sum_full_n=1 always.
  - RAM contents are not cleared.
- Reference RAM: synchronous write, asynchronous read.
  - ref_wr_en is honoured only in IDLE and ignored otherwise.
  - sad_ref_dout = ram[ref_idx].
- States and transitions:
  - IDLE: on an arm rising edge with num_points != 0, latch num_points to npts and threshold to thr, clear overrun, then go to START. With num_points == 0, stay in IDLE.
  - START: wait for sad_idle=1. Then assert sad_start for exactly one cycle, set ref_idx=0, and go to LOADREF.
  - LOADREF: sad_ref_empty_n=1. Each cycle with sad_ref_read=1, ref_idx increments. After npts reads, sad_ref_empty_n drops in the following cycle, and the state moves to RUN with warmup=0.
  - RUN: streams samples (see sample path) and watches results (see result path).
  - RECYCLE: sad_rst=1 for one cycle, then return to IDLE.
- Sample path (RUN only):
  - One-deep holding register; the stored value is adc_data - 512, i.e. adc_data with the MSB inverted, treated as signed DW.
  - sad_data_empty_n equals the holding-valid bit.
  - A read clears the valid bit.
  - adc_valid with a simultaneous read loads the new sample and keeps valid=1.
  - adc_valid while valid=1 and no read: the new sample overwrites the old one and overrun sets (sticky).
  - ADC samples are ignored outside RUN.
- Result path (RUN):
  - Each sad_sum_write updates last_sum.
  - The first npts-1 results increment warmup and cannot trigger.
  - After warmup, if sad_sum_din < thr (unsigned, strict), trigger=1 in the next cycle and the state goes to RECYCLE.
- Abort: arm=0 in START, LOADREF or RUN goes to RECYCLE with no trigger.
  - arm=0 in the same cycle as a qualifying result: the trigger is suppressed and abort wins.
- ap_rst mid-operation: immediate return to IDLE; the holding register is cleared.

Test Plan:
- Write ram[0..3] = {5,-3,7,0}, npts=4, pulse arm, sad_idle=1 → sad_start high for one cycle; sad_ref_dout presents 5,-3,7,0 on successive reads; sad_ref_empty_n=0 after the 4th read.
- In RUN, adc_data=512 then 515 → sad_data_dout = 0 then 3 as signed values.
- thr=100, npts=4, results 50,50,50,99 → the first three are ignored; trigger pulses one cycle after the 4th write, followed by sad_rst for one cycle, then IDLE; last_sum=99.
- Result equal to thr=100 after warmup → no trigger; state stays RUN.
- adc_valid for two consecutive cycles with sad_data_read=0 → overrun=1; the holding register contains the second sample.
- Drop arm during LOADREF → sad_rst pulse, busy=0, no trigger. A ref_wr_en issued while busy leaves RAM unchanged.

Source files
------------

// File: rtl/sad_trigger_ctrl.sv
// Sequencer and configuration front-end for the HLS SAD core: holds the reference
// waveform, feeds the core's ref/data FIFO ports and fires a trigger on a low SAD.
module sad_trigger_ctrl #(
   parameter int REF_DEPTH = 128,
   parameter int DW        = 10,
   parameter int SUMW      = 20,
   localparam int AW       = $clog2(REF_DEPTH)
) (
   input  logic            ap_clk,
   input  logic            ap_rst,
   input  logic            arm,
   input  logic [AW-1:0]   num_points,
   input  logic [SUMW-1:0] threshold,
   input  logic            ref_wr_en,
   input  logic [AW-1:0]   ref_wr_addr,
   input  logic [DW-1:0]   ref_wr_data,
   input  logic [DW-1:0]   adc_data,
   input  logic            adc_valid,
   output logic            sad_rst,
   output logic            sad_start,
   input  logic            sad_idle,
   output logic [DW-1:0]   sad_ref_dout,
   output logic            sad_ref_empty_n,
   input  logic            sad_ref_read,
   output logic [DW-1:0]   sad_data_dout,
   output logic            sad_data_empty_n,
   input  logic            sad_data_read,
   input  logic [SUMW-1:0] sad_sum_din,
   input  logic            sad_sum_write,
   output logic            sad_sum_full_n,
   output logic            trigger,
   output logic            busy,
   output logic [SUMW-1:0] last_sum,
   output logic            overrun,
   output logic [2:0]      dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_LOADREF = 3'd2,
      S_RUN     = 3'd3,
      S_RECYCLE = 3'd4
   } state_t;

   // Inverting the MSB turns offset-binary ADC codes into signed two's complement.
   localparam logic [DW-1:0] SIGN_FLIP = DW'(1) << (DW - 1);

   state_t          state_q;
   logic            arm_q;
   logic [AW-1:0]   npts_q;
   logic [SUMW-1:0] thr_q;
   logic [AW-1:0]   ref_idx_q;
   logic [AW-1:0]   warmup_q;
   logic [DW-1:0]   hold_q;
   logic            hold_v_q;
   logic [SUMW-1:0] last_sum_q;
   logic            overrun_q;
   logic            trigger_q;
   logic            start_q;
   logic            ref_en_q;
   logic [DW-1:0]   ram_q [REF_DEPTH];

   logic            arm_rise;
   logic [AW-1:0]   ref_idx_d;
   logic            warmup_active;
   logic            result_hit;

   assign arm_rise      = arm & ~arm_q;
   assign ref_idx_d     = ref_idx_q + AW'(1);
   assign warmup_active = warmup_q < (npts_q - AW'(1));
   assign result_hit    = sad_sum_write & ~warmup_active & (sad_sum_din < thr_q);

   always_ff @(posedge ap_clk) begin
      if (!ap_rst && ref_wr_en && state_q == S_IDLE) begin
         ram_q[ref_wr_addr] <= ref_wr_data;
      end
   end

   always_ff @(posedge ap_clk) begin
      arm_q <= arm;
      if (ap_rst) begin
         state_q    <= S_IDLE;
         npts_q     <= '0;
         thr_q      <= '0;
         ref_idx_q  <= '0;
         warmup_q   <= '0;
         hold_q     <= '0;
         hold_v_q   <= 1'b0;
         last_sum_q <= '0;
         overrun_q  <= 1'b0;
         trigger_q  <= 1'b0;
         start_q    <= 1'b0;
         ref_en_q   <= 1'b0;
      end else begin
         trigger_q <= 1'b0;
         start_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               hold_v_q <= 1'b0;
               if (arm_rise && num_points != '0) begin
                  npts_q    <= num_points;
                  thr_q     <= threshold;
                  overrun_q <= 1'b0;
                  state_q   <= S_START;
               end
            end
            S_START: begin
               if (!arm) begin
                  state_q <= S_RECYCLE;
               end else if (sad_idle) begin
                  start_q   <= 1'b1;
                  ref_idx_q <= '0;
                  ref_en_q  <= 1'b1;
                  state_q   <= S_LOADREF;
               end
            end
            S_LOADREF: begin
               if (!arm) begin
                  ref_en_q <= 1'b0;
                  state_q  <= S_RECYCLE;
               end else if (sad_ref_read) begin
                  ref_idx_q <= ref_idx_d;
                  if (ref_idx_d == npts_q) begin
                     ref_en_q <= 1'b0;
                     warmup_q <= '0;
                     state_q  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (adc_valid) begin
                  hold_q   <= adc_data ^ SIGN_FLIP;
                  hold_v_q <= 1'b1;
                  if (hold_v_q && !sad_data_read) overrun_q <= 1'b1;
               end else if (sad_data_read) begin
                  hold_v_q <= 1'b0;
               end
               if (sad_sum_write) begin
                  last_sum_q <= sad_sum_din;
                  if (warmup_active) warmup_q <= warmup_q + AW'(1);
               end
               // Abort outranks a qualifying result arriving in the same cycle.
               if (!arm || result_hit) begin
                  hold_v_q  <= 1'b0;
                  trigger_q <= arm;
                  state_q   <= S_RECYCLE;
               end
            end
            S_RECYCLE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign sad_rst          = ap_rst | (state_q == S_RECYCLE);
   assign sad_start        = start_q;
   assign sad_ref_dout     = ram_q[ref_idx_q];
   assign sad_ref_empty_n  = ref_en_q;
   assign sad_data_dout    = hold_q;
   assign sad_data_empty_n = hold_v_q;
   assign sad_sum_full_n   = 1'b1;
   assign trigger          = trigger_q;
   assign busy             = state_q != S_IDLE;
   assign last_sum         = last_sum_q;
   assign overrun          = overrun_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sad_trigger_ctrl.sv
// Bench for sad_trigger_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_sad_trigger_ctrl;

  logic        clk = 1'b0;
  logic        ap_rst, arm, ref_wr_en, adc_valid, sad_idle, sad_ref_read;
  logic        sad_data_read, sad_sum_write;
  logic [6:0]  num_points, ref_wr_addr;
  logic [19:0] threshold, sad_sum_din;
  logic [9:0]  ref_wr_data, adc_data;
  logic        sad_rst, sad_start, sad_ref_empty_n, sad_data_empty_n, sad_sum_full_n;
  logic        trigger, busy, overrun;
  logic [9:0]  sad_ref_dout, sad_data_dout;
  logic [19:0] last_sum;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  sad_trigger_ctrl dut (
    .ap_clk(clk), .ap_rst(ap_rst), .arm(arm), .num_points(num_points),
    .threshold(threshold), .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr),
    .ref_wr_data(ref_wr_data), .adc_data(adc_data), .adc_valid(adc_valid),
    .sad_rst(sad_rst), .sad_start(sad_start), .sad_idle(sad_idle),
    .sad_ref_dout(sad_ref_dout), .sad_ref_empty_n(sad_ref_empty_n),
    .sad_ref_read(sad_ref_read), .sad_data_dout(sad_data_dout),
    .sad_data_empty_n(sad_data_empty_n), .sad_data_read(sad_data_read),
    .sad_sum_din(sad_sum_din), .sad_sum_write(sad_sum_write),
    .sad_sum_full_n(sad_sum_full_n), .trigger(trigger), .busy(busy),
    .last_sum(last_sum), .overrun(overrun), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_WAIT = 1, P_LOAD = 2, P_RUN = 3, P_RECYC = 4;
  int m_phase = P_IDLE;
  int m_npts, m_thr, m_reads, m_results, m_hold, m_last;
  bit m_hold_v, m_ovr, m_trig, m_start, m_ref_en, m_arm_prev, m_rise, m_hit;
  int m_ram [128];

  task automatic model_step();
    m_rise     = arm && !m_arm_prev;
    m_arm_prev = arm;
    if (ap_rst) begin
      m_phase = P_IDLE; m_trig = 0; m_start = 0; m_ref_en = 0; m_hold_v = 0;
      m_last = 0; m_ovr = 0; m_reads = 0; m_hold = 0;
      return;
    end
    if (m_phase == P_IDLE && ref_wr_en) m_ram[ref_wr_addr] = int'(ref_wr_data);
    m_trig = 0;
    m_start = 0;
    case (m_phase)
      P_IDLE: if (m_rise && num_points != 0) begin
        m_npts = int'(num_points); m_thr = int'(threshold); m_ovr = 0; m_phase = P_WAIT;
      end
      P_WAIT: if (!arm) m_phase = P_RECYC;
              else if (sad_idle) begin
                m_start = 1; m_reads = 0; m_ref_en = 1; m_phase = P_LOAD;
              end
      P_LOAD: if (!arm) begin
                m_ref_en = 0; m_phase = P_RECYC;
              end else if (sad_ref_read) begin
                m_reads++;
                if (m_reads == m_npts) begin
                  m_ref_en = 0; m_results = 0; m_phase = P_RUN;
                end
              end
      P_RUN: begin
        if (adc_valid) begin
          if (m_hold_v && !sad_data_read) m_ovr = 1;
          m_hold = (int'(adc_data) - 512) & 1023;
          m_hold_v = 1;
        end else if (sad_data_read) m_hold_v = 0;
        m_hit = 0;
        if (sad_sum_write) begin
          m_last = int'(sad_sum_din);
          if (m_results < m_npts - 1) m_results++;
          else m_hit = int'(sad_sum_din) < m_thr;
        end
        if (!arm) begin
          m_hold_v = 0; m_phase = P_RECYC;
        end else if (m_hit) begin
          m_trig = 1; m_hold_v = 0; m_phase = P_RECYC;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("trigger", 32'(trigger), 32'(m_trig));
      chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
      chk("dbg_state_idle", 32'(dbg_state == 3'd0), 32'(m_phase == P_IDLE));
      chk("sad_rst", 32'(sad_rst), 32'(ap_rst || m_phase == P_RECYC));
      chk("sad_start", 32'(sad_start), 32'(m_start));
      chk("ref_empty_n", 32'(sad_ref_empty_n), 32'(m_ref_en));
      chk("data_empty_n", 32'(sad_data_empty_n), 32'(m_hold_v));
      chk("last_sum", 32'(last_sum), 32'(m_last));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("sum_full_n", 32'(sad_sum_full_n), 32'd1);
      if (m_ref_en) chk("ref_dout", 32'(sad_ref_dout), 32'(m_ram[m_reads]));
      if (m_hold_v) chk("data_dout", 32'(sad_data_dout), 32'(m_hold));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ap_rst = 1; arm = 0; num_points = 0; threshold = 0; ref_wr_en = 0;
    ref_wr_addr = 0; ref_wr_data = 0; adc_data = 0; adc_valid = 0; sad_idle = 0;
    sad_ref_read = 0; sad_data_read = 0; sad_sum_din = 0; sad_sum_write = 0;
    tick();
    chk_en = 1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trigger", 32'(trigger), 32'd0);
    chk("rst_sad_rst", 32'(sad_rst), 32'd1);
    chk("rst_last_sum", 32'(last_sum), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_empty_n", 32'({sad_ref_empty_n, sad_data_empty_n, sad_start}), 32'd0);
    ap_rst = 0;
    tick();
    chk("rel_sad_rst", 32'(sad_rst), 32'd0);

    // fill the whole reference RAM, then the known prefix
    for (int i = 0; i < 132; i++) begin
      ref_wr_en = 1;
      ref_wr_addr = (i < 128) ? 7'(i) : 7'(i - 128);
      case (i)
        128: ref_wr_data = 10'd5;
        129: ref_wr_data = 10'h3FD;
        130: ref_wr_data = 10'd7;
        131: ref_wr_data = 10'd0;
        default: ref_wr_data = 10'($urandom_range(0, 1023));
      endcase
      tick();
    end
    ref_wr_en = 0;

    // start and reference load
    arm = 1; num_points = 4; threshold = 100; sad_idle = 1;
    tick(); tick();
    chk("start_pulse", 32'(sad_start), 32'd1);
    chk("ref0", 32'(sad_ref_dout), 32'd5);
    sad_ref_read = 1;
    tick();
    chk("start_one_cycle", 32'(sad_start), 32'd0);
    chk("ref1", 32'(sad_ref_dout), 32'd1021);
    tick();
    chk("ref2", 32'(sad_ref_dout), 32'd7);
    tick();
    chk("ref3", 32'(sad_ref_dout), 32'd0);
    chk("ref_empty_n_before_last", 32'(sad_ref_empty_n), 32'd1);
    tick();
    chk("ref_empty_n_after_last", 32'(sad_ref_empty_n), 32'd0);
    sad_ref_read = 0;

    // sample path
    adc_valid = 1; adc_data = 10'd512;
    tick();
    chk("sample0_valid", 32'(sad_data_empty_n), 32'd1);
    chk("sample0", 32'(sad_data_dout), 32'd0);
    adc_data = 10'd515; sad_data_read = 1;
    tick();
    chk("sample1", 32'(sad_data_dout), 32'd3);
    chk("no_overrun", 32'(overrun), 32'd0);
    adc_valid = 0;
    tick();
    chk("read_clears", 32'(sad_data_empty_n), 32'd0);
    sad_data_read = 0;
    adc_valid = 1; adc_data = 10'd600;
    tick();
    adc_data = 10'd700;
    tick();
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_keeps_newest", 32'(sad_data_dout), 32'd188);
    adc_valid = 0;

    // result path: three warmup results, an equal one, then a hit
    sad_sum_write = 1; sad_sum_din = 50;
    tick(); tick(); tick();
    chk("warmup_no_trig", 32'(trigger), 32'd0);
    sad_sum_din = 100;
    tick();
    chk("equal_no_trig", 32'(trigger), 32'd0);
    chk("equal_stays_busy", 32'(busy), 32'd1);
    chk("last_sum_100", 32'(last_sum), 32'd100);
    sad_sum_din = 99;
    tick();
    chk("trig_pulse", 32'(trigger), 32'd1);
    chk("trig_sad_rst", 32'(sad_rst), 32'd1);
    chk("last_sum_99", 32'(last_sum), 32'd99);
    sad_sum_write = 0;
    tick();
    chk("trig_one_cycle", 32'(trigger), 32'd0);
    chk("back_idle", 32'(busy), 32'd0);

    // abort during reference load, with a write attempt while busy
    arm = 0;
    tick();
    arm = 1; num_points = 4;
    tick(); tick();
    chk("loadref_busy", 32'(busy), 32'd1);
    arm = 0; ref_wr_en = 1; ref_wr_addr = 0; ref_wr_data = 10'd99;
    tick();
    chk("abort_sad_rst", 32'(sad_rst), 32'd1);
    chk("abort_no_trig", 32'(trigger), 32'd0);
    ref_wr_en = 0;
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    arm = 1; num_points = 1;
    tick(); tick();
    chk("ram_unchanged", 32'(sad_ref_dout), 32'd5);
    arm = 0;
    tick(); tick();

    // zero-length reference never starts
    arm = 1; num_points = 0;
    tick(); tick();
    chk("zero_points_idle", 32'(busy), 32'd0);

    // randomized traffic
    for (int c = 0; c < 6000; c++) begin
      ap_rst = ($urandom_range(0, 799) == 0);
      if (m_phase == P_IDLE) begin
        if ($urandom_range(0, 1) == 0) arm = ~arm;
        num_points = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
        threshold = 20'($urandom_range(0, 400));
      end else begin
        arm = ($urandom_range(0, 79) != 0);
      end
      ref_wr_en = ($urandom_range(0, 3) == 0);
      ref_wr_addr = 7'($urandom_range(0, 127));
      ref_wr_data = 10'($urandom_range(0, 1023));
      adc_valid = ($urandom_range(0, 1) == 0);
      adc_data = 10'($urandom_range(0, 1023));
      sad_idle = ($urandom_range(0, 1) == 0);
      sad_ref_read = m_ref_en && ($urandom_range(0, 3) != 0);
      sad_data_read = m_hold_v && ($urandom_range(0, 1) == 0);
      sad_sum_write = ($urandom_range(0, 2) == 0);
      sad_sum_din = 20'($urandom_range(0, 500));
      tick();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
